// File: rtl/uart_rx_fifo.sv
// Purpose : byte FIFO from the UART receiver to the CPU data register, with threshold/idle-timeout/overflow interrupt.
// Latency : pushed byte visible on rdata/count one cycle after the push edge; next head visible one cycle after a pop.
// Backpr.  : no backpressure to the receiver; a push into a full FIFO without a same-cycle pop is dropped and flagged.
//
// Ports:
//   clk, reset        - system clock, synchronous active-low reset
//   rx_data/rx_valid  - push side (one-cycle strobe per received byte)
//   rd_pop            - pop strobe from the bus read of the data register
//   ovf_clr           - clears the sticky overflow flag
//   thresh            - fill level at or above which irq asserts (0 disables)
//   rdata             - head byte (first-word-fall-through), 8'h00 when empty
//   count/empty/full  - occupancy status
//   overflow/timeout  - sticky drop flag, idle-with-data flag
//   irq               - registered interrupt request
module uart_rx_fifo #(
    parameter int          DEPTH_LOG2     = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_pop,
    input  logic                  ovf_clr,
    input  logic [DEPTH_LOG2:0]   thresh,
    output logic [7:0]            rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  irq
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam int                CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [15:0]           idle_cnt;

    logic                  pop_ok;
    logic                  push_ok;
    logic                  drop;
    logic [CW-1:0]         count_nxt;
    logic                  overflow_nxt;
    logic                  timeout_nxt;
    logic [15:0]           idle_nxt;
    logic                  irq_nxt;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = empty ? 8'h00 : mem[rptr];

    always_comb begin
        pop_ok       = 1'b0;
        push_ok      = 1'b0;
        drop         = 1'b0;
        count_nxt    = count;
        overflow_nxt = overflow;
        timeout_nxt  = timeout;
        idle_nxt     = idle_cnt;
        irq_nxt      = 1'b0;

        // A pop on empty is ignored; a pop on full frees the slot for a same-cycle push.
        pop_ok  = rd_pop && !empty;
        push_ok = rx_valid && (!full || pop_ok);
        drop    = rx_valid && full && !rd_pop;

        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        // Set wins over clear.
        if (drop)
            overflow_nxt = 1'b1;
        else if (ovf_clr)
            overflow_nxt = 1'b0;

        // Idle timer only runs while data sits untouched; saturates at the limit.
        if (rx_valid || rd_pop || empty)
            idle_nxt = 16'd0;
        else if (idle_cnt != TIMEOUT_CYCLES)
            idle_nxt = idle_cnt + 16'd1;

        // A push alone keeps the flag: the CPU still has not drained the stale data.
        if (rd_pop || empty)
            timeout_nxt = 1'b0;
        else if (!rx_valid && (idle_cnt == TIMEOUT_CYCLES - 16'd1))
            timeout_nxt = 1'b1;

        irq_nxt = ((thresh != '0) && (count_nxt >= thresh)) || timeout_nxt || overflow_nxt;
    end

    // Storage has no reset; writes are blocked during reset so that cycle's push is discarded.
    always_ff @(posedge clk) begin
        if (reset && push_ok)
            mem[wptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            idle_cnt <= 16'd0;
            irq      <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + DEPTH_LOG2'(1);
            if (pop_ok)
                rptr <= rptr + DEPTH_LOG2'(1);
            count    <= count_nxt;
            overflow <= overflow_nxt;
            timeout  <= timeout_nxt;
            idle_cnt <= idle_nxt;
            irq      <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed self-checking bench for uart_rx_fifo (depth 16, timeout 10).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpr.  : n/a
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_pop;
    logic       ovf_clr;
    logic [4:0] thresh;
    logic [7:0] rdata;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       timeout;
    logic       irq;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(
        .DEPTH_LOG2     (4),
        .TIMEOUT_CYCLES (16'd10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_pop   (rd_pop),
        .ovf_clr  (ovf_clr),
        .thresh   (thresh),
        .rdata    (rdata),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .timeout  (timeout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; strobes drop back to 0.
    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rd_pop   = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_b;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rd_pop   = 1'b0;
        ovf_clr  = 1'b0;
        thresh   = 5'd0;
        tick();
        tick();

        // Reset state
        chk("rst_count",    count,    0);
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout",  timeout,  0);
        chk("rst_irq",      irq,      0);
        chk("rst_rdata",    rdata,    8'h00);
        reset = 1'b1;
        tick();

        // Single byte in and out
        push(8'hA5);
        chk("one_rdata", rdata, 8'hA5);
        chk("one_count", count, 1);
        chk("one_empty", empty, 0);
        pop();
        chk("one_pop_count", count, 0);
        chk("one_pop_empty", empty, 1);
        chk("one_pop_rdata", rdata, 8'h00);

        // Fill, overflow, ordered drain
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full_pre", full, 1);
        push(8'hFF);
        chk("ovf_full",     full,     1);
        chk("ovf_count",    count,    16);
        chk("ovf_overflow", overflow, 1);
        chk("ovf_irq",      irq,      1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", rdata, 8'(i));
            pop();
        end
        chk("drain_empty",  empty,    1);
        chk("drain_ovf",    overflow, 1);
        ovf_clr = 1'b1;
        tick();
        chk("ovfclr_overflow", overflow, 0);
        chk("ovfclr_irq",      irq,      0);

        // Push + pop while full
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        rd_pop   = 1'b1;
        tick();
        chk("fullpp_count",    count,    16);
        chk("fullpp_overflow", overflow, 0);
        chk("fullpp_full",     full,     1);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h21 + i) : 8'h55;
            chk("fullpp_drain", rdata, exp_b);
            pop();
        end
        chk("fullpp_empty", empty, 1);

        // Push + pop while empty, then pop on empty
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        rd_pop   = 1'b1;
        tick();
        chk("emptypp_count", count, 1);
        chk("emptypp_rdata", rdata, 8'h3C);
        pop();
        pop();
        chk("underflow_count", count, 0);
        chk("underflow_empty", empty, 1);

        // Threshold interrupt
        thresh = 5'd4;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("thr_count3", count, 3);
        chk("thr_irq3",   irq,   0);
        push(8'h04);
        chk("thr_irq4",   irq,   1);
        pop();
        chk("thr_pop_count", count, 3);
        chk("thr_pop_irq",   irq,   0);
        pop();
        pop();
        pop();
        chk("thr_drained", empty, 1);
        thresh = 5'd0;

        // Idle timeout: sets exactly 10 cycles after the push edge
        push(8'h77);
        for (int i = 1; i < 10; i++) tick();
        chk("tmo_9",     timeout, 0);
        tick();
        chk("tmo_10",    timeout, 1);
        chk("tmo_irq",   irq,     1);
        push(8'h78);
        chk("tmo_push_keeps", timeout, 1);
        pop();
        chk("tmo_pop_clears", timeout, 0);
        chk("tmo_pop_irq",    irq,     0);
        chk("tmo_pop_rdata",  rdata,   8'h78);

        // Reset mid-stream with 5 buffered; a push in the reset cycle is discarded
        for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
        chk("pre_rst_count", count, 5);
        reset    = 1'b0;
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        tick();
        chk("mid_rst_count",    count,    0);
        chk("mid_rst_empty",    empty,    1);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_timeout",  timeout,  0);
        chk("mid_rst_irq",      irq,      0);
        reset = 1'b1;
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_rdata", rdata, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
